// File: rtl/buffer_arbiter_pkg.sv
// Shared definitions for buffer_arbiter.
// Provides the source-id width rule and the packed pipeline-stage record
// layout {valid, id[IDW], data[W]}.
package buffer_arbiter_pkg;

  // Source-id width: clog2 of the requester count, never below one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width of one packed stage record: valid + id + data.
  function automatic int unsigned stage_w(input int unsigned idw, input int unsigned w);
    return 1 + idw + w;
  endfunction

endpackage

// File: rtl/buffer_arbiter_if.sv
// Requester/consumer bundle for buffer_arbiter.
//   req       N      per-requester request
//   data_in   N*W    requester i's word in bits [i*W +: W]
//   grant     N      one-hot grant
//   out_valid 1      tail word valid
//   out_data  W      tail word
//   out_id    IDW    source index of out_data
//   out_ready 1      downstream accepts tail word
// slave: arbiter side; master: producers/consumer side.
interface buffer_arbiter_if
  import buffer_arbiter_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned W   = 8,
  parameter int unsigned IDW = id_width(N)
);
  logic [N-1:0]   req;
  logic [N*W-1:0] data_in;
  logic [N-1:0]   grant;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [IDW-1:0] out_id;
  logic           out_ready;

  modport slave (
    input  req, data_in, out_ready,
    output grant, out_valid, out_data, out_id
  );

  modport master (
    output req, data_in, out_ready,
    input  grant, out_valid, out_data, out_id
  );
endinterface

// File: rtl/buffer_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req    N    request vector
//   ptr    IDW  highest-priority index
//   onehot N    one-hot winner (0 when no request)
//   idx    IDW  winner index
//   any    1    at least one request present
module buffer_arbiter_rr_pick
  import buffer_arbiter_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = id_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   onehot,
  output logic [IDW-1:0] idx,
  output logic           any
);
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int unsigned    off;
  int unsigned    sum;

  // Rotate so ptr sits at bit 0, priority-encode, then rotate the index back.
  always_comb begin
    dbl    = {req, req} >> ptr;
    rot    = dbl[N-1:0];
    any    = 1'b0;
    off    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!any && rot[k]) begin
        any = 1'b1;
        off = k;
      end
    end
    sum = 32'(ptr) + off;
    if (sum >= N) sum = sum - N;
    idx    = IDW'(sum);
    onehot = any ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/buffer_arbiter.sv
// Round-robin arbiter feeding a shared DEPTH-stage registered pipeline.
// Each non-stalled cycle at most one requester is granted; its word and
// source id emerge at the tail DEPTH cycles later. out_ready back-pressure
// freezes all stages and the pointer and suppresses grants.
//   clk    clock
//   reset  synchronous active-high reset
//   bus    buffer_arbiter_if.slave (req/data_in/grant/out_*)
module buffer_arbiter
  import buffer_arbiter_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned IDW   = id_width(N)
) (
  input  logic             clk,
  input  logic             reset,
  buffer_arbiter_if.slave  bus
);
  localparam int unsigned SW = stage_w(IDW, W);

  logic [IDW-1:0] ptr;
  logic [N-1:0]   win_onehot;
  logic [IDW-1:0] win_idx;
  logic           win_any;
  logic           stall;
  logic           take;
  logic [W-1:0]   data_sel;
  logic [SW-1:0]  head;
  logic [SW-1:0]  tail;

  buffer_arbiter_rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .onehot (win_onehot),
    .idx    (win_idx),
    .any    (win_any)
  );

  assign stall     = bus.out_valid && !bus.out_ready;
  assign take      = win_any && !stall && !reset;
  assign bus.grant = take ? win_onehot : '0;

  always_comb begin
    data_sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (win_idx == IDW'(i)) data_sel = bus.data_in[i*W +: W];
    end
  end

  // A non-granting cycle still shifts a bubble into the head stage.
  assign head = take ? {1'b1, win_idx, data_sel} : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (take) begin
      ptr <= (win_idx == IDW'(N-1)) ? '0 : win_idx + 1'b1;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [SW-1:0] q;
    logic [SW-1:0] d;
    if (k == 0) begin : g_head
      assign d = head;
    end else begin : g_body
      assign d = g_stage[k-1].q;
    end
    always_ff @(posedge clk) begin
      if (reset)       q <= '0;
      else if (!stall) q <= d;
    end
  end

  assign tail          = g_stage[DEPTH-1].q;
  assign bus.out_valid = tail[SW-1];
  assign bus.out_id    = tail[W +: IDW];
  assign bus.out_data  = tail[W-1:0];
endmodule

// File: tb/tb_buffer_arbiter.sv
module tb_buffer_arbiter;
  localparam int unsigned N = 4;
  localparam int unsigned W = 8;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned IDW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  buffer_arbiter_if #(.N(N), .W(W), .IDW(IDW)) bus ();

  buffer_arbiter #(.N(N), .W(W), .DEPTH(DEPTH), .IDW(IDW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int unsigned id;
    logic [W-1:0] data;
    int unsigned  cyc;
    int unsigned  sc;
  } ent_t;

  ent_t        sb[$];
  int unsigned mptr = 0;
  int unsigned cyc = 0;
  int unsigned sc = 0;
  bit          head_seen = 0;
  bit          prev_reset = 0;
  bit          mon_on = 0;

  function automatic logic [N-1:0] model_grant(input logic [N-1:0] r, input int unsigned p);
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned j;
      j = (p + k) % N;
      if (r[j]) return N'(1) << j;
    end
    return '0;
  endfunction

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_on) begin
      logic [N-1:0] eg;
      bit st;
      if (reset) begin
        check_val("grant_in_reset", 32'(bus.grant), 0);
        if (prev_reset)
          check_val("out_in_reset", {22'd0, bus.out_valid, bus.out_id, bus.out_data}, 0);
        sb.delete();
        head_seen = 0;
        mptr = 0;
        prev_reset = 1;
      end else begin
        if (prev_reset)
          check_val("out_after_reset", {22'd0, bus.out_valid, bus.out_id, bus.out_data}, 0);
        prev_reset = 0;
        st = bus.out_valid && !bus.out_ready;
        eg = st ? '0 : model_grant(bus.req, mptr);
        check_val("grant", 32'(bus.grant), 32'(eg));
        if (bus.out_valid) begin
          if (sb.size() == 0) begin
            check_val("unexpected_out", 1, 0);
          end else begin
            check_val("out_id", 32'(bus.out_id), sb[0].id);
            check_val("out_data", 32'(bus.out_data), 32'(sb[0].data));
            if (!head_seen)
              check_val("latency", cyc - sb[0].cyc - (sc - sb[0].sc), DEPTH);
            head_seen = 1;
            if (bus.out_ready) begin
              void'(sb.pop_front());
              head_seen = 0;
            end
          end
        end
        if (eg != '0) begin
          ent_t e;
          e.id = $clog2(eg);
          e.data = bus.data_in[e.id*W +: W];
          e.cyc = cyc;
          e.sc = sc;
          sb.push_back(e);
          mptr = (e.id + 1) % N;
        end
        if (st) sc++;
      end
      cyc++;
    end
  end

  task automatic drive(input logic [N-1:0] r, input logic rdy);
    @(posedge clk);
    #1;
    bus.req = r;
    bus.out_ready = rdy;
  endtask

  initial begin
    int unsigned vcount;
    reset = 1'b1;
    bus.req = 4'b1111;
    bus.data_in = 32'h40302010;
    bus.out_ready = 1'b1;
    mon_on = 1;

    // 1. reset held 3 cycles with all requesting
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;

    // 2. rotation
    @(negedge clk); check_val("rot0", 32'(bus.grant), 32'b0001);
    @(negedge clk); check_val("rot1", 32'(bus.grant), 32'b0010);
    @(negedge clk); check_val("rot2", 32'(bus.grant), 32'b0100);
    @(negedge clk); check_val("rot3", 32'(bus.grant), 32'b1000);
    @(negedge clk); check_val("rot4", 32'(bus.grant), 32'b0001);

    // 3. pointer skip
    drive(4'b0010, 1'b1);
    @(negedge clk); check_val("skip_g1", 32'(bus.grant), 32'b0010);
    drive(4'b1001, 1'b1);
    @(negedge clk); check_val("skip_g3", 32'(bus.grant), 32'b1000);
    @(negedge clk); check_val("skip_g0", 32'(bus.grant), 32'b0001);

    // 4. back-pressure for 3 cycles while streaming
    bus.data_in = 32'h87868584;
    drive(4'b1111, 1'b1);
    repeat (2) @(negedge clk);
    drive(4'b1111, 1'b0);
    @(negedge clk);
    check_val("bp_valid", 32'(bus.out_valid), 1);
    check_val("bp_grant0", 32'(bus.grant), 0);
    repeat (2) begin
      @(posedge clk); #1;
      @(negedge clk); check_val("bp_grant", 32'(bus.grant), 0);
    end
    drive(4'b1111, 1'b1);
    repeat (2) @(negedge clk);
    drive(4'b0000, 1'b1);
    repeat (4) @(negedge clk);

    // 5. single pulse with out_ready low during bubbles
    bus.data_in = 32'h00A50000;
    drive(4'b0100, 1'b0);
    vcount = 0;
    @(negedge clk);
    check_val("pulse_grant", 32'(bus.grant), 32'b0100);
    drive(4'b0000, 1'b0);
    @(negedge clk);
    check_val("bubble_valid", 32'(bus.out_valid), 0);
    drive(4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check_val("pulse_id", 32'(bus.out_id), 2);
        check_val("pulse_data", 32'(bus.out_data), 32'hA5);
      end
      if (bus.out_valid) vcount++;
      @(posedge clk); #1;
    end
    check_val("pulse_count", vcount, 1);

    // 6. reset mid-operation; ptr advanced to 2 beforehand
    bus.data_in = 32'hDDCCBBAA;
    drive(4'b0010, 1'b1);
    @(posedge clk); #1 reset = 1'b1; bus.req = 4'b1111;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_val("rst_out_valid", 32'(bus.out_valid), 0);
    check_val("rst_ptr_grant", 32'(bus.grant), 32'b0001);
    drive(4'b0000, 1'b1);
    repeat (5) @(negedge clk);
    check_val("drain_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
